// File: rtl/stream_mux_n.sv
// stream_mux_n
//   N:1 stream multiplexer with one registered output stage and optional
//   packet locking. The selected channel is forwarded into a single output
//   register at full throughput. With LOCK_EN=1 the channel chosen on the
//   first beat of a packet is held until that channel's LAST beat, so a
//   multi-beat transfer cannot be split by a SEL change. An out-of-range SEL
//   falls back to channel 0 and raises SEL_ERR alongside the beat it moved.
//
// Ports
//   CLK        rising-edge clock
//   RST        synchronous, active-high reset
//   SEL        channel select (SEL_W bits)
//   D          flattened inputs, channel i at D[i*WIDTH +: WIDTH]
//   IN_LAST    per-channel end-of-packet marker
//   IN_VALID   per-channel valid
//   IN_READY   per-channel ready (only the effective channel can be ready)
//   DOUT       registered output data
//   OUT_LAST   registered LAST of the output beat
//   OUT_VALID  output valid
//   OUT_READY  downstream ready
//   SEL_ERR    registered flag: the output beat was taken via an
//              out-of-range SEL
//   LOCKED     a packet is in progress and the channel is held
//
// Handshake: a beat moves on a channel in any cycle where both valid and
// ready are high at the rising clock edge. A producer holds its beat until
// then; ready never depends on anything a producer drives on the same
// channel, so valid may wait on ready without deadlock.

module stream_mux_n #(
    parameter int NUM_IN  = 4,
    parameter int WIDTH   = 32,
    parameter int SEL_W   = ($clog2(NUM_IN) < 1) ? 1 : $clog2(NUM_IN),
    parameter bit LOCK_EN = 1'b1
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [SEL_W-1:0]        SEL,
    input  logic [NUM_IN*WIDTH-1:0] D,
    input  logic [NUM_IN-1:0]       IN_LAST,
    input  logic [NUM_IN-1:0]       IN_VALID,
    output logic [NUM_IN-1:0]       IN_READY,
    output logic [WIDTH-1:0]        DOUT,
    output logic                    OUT_LAST,
    output logic                    OUT_VALID,
    input  logic                    OUT_READY,
    output logic                    SEL_ERR,
    output logic                    LOCKED
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [SEL_W-1:0]   held_q;
    logic [SEL_W-1:0]   held_d;

    logic [WIDTH-1:0]   dout_q;
    logic               last_q;
    logic               valid_q;
    logic               err_q;

    logic [SEL_W-1:0]   ch;
    logic               sel_bad;
    logic               stage_en;
    logic [WIDTH-1:0]   ch_data;
    logic               ch_last;
    logic               ch_valid;
    logic [NUM_IN-1:0]  ready_vec;
    logic               acc;

    // The output register can take a new beat when it is empty or is being
    // drained this very cycle.
    assign stage_en = !valid_q || OUT_READY;

    // Effective channel. While a packet is locked the held channel wins and
    // SEL (including a bad SEL) is ignored entirely.
    always_comb begin
        ch      = '0;
        sel_bad = 1'b0;
        if (LOCK_EN && (state_q == ST_LOCKED)) begin
            ch = held_q;
        end else if (int'(SEL) < NUM_IN) begin
            ch = SEL;
        end else begin
            ch      = '0;
            sel_bad = 1'b1;
        end
    end

    // Channel mux written as a compare loop so the select width never has
    // to match the width of the per-channel vectors.
    always_comb begin
        ch_data   = '0;
        ch_last   = 1'b0;
        ch_valid  = 1'b0;
        ready_vec = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (i == int'(ch)) begin
                ch_data      = D[i*WIDTH +: WIDTH];
                ch_last      = IN_LAST[i];
                ch_valid     = IN_VALID[i];
                ready_vec[i] = stage_en && !RST;
            end
        end
    end

    assign IN_READY = ready_vec;
    assign acc      = ch_valid && stage_en && !RST;

    // Packet-lock FSM: a non-LAST accepted beat in IDLE captures the
    // channel; the LAST beat of that channel releases it.
    always_comb begin
        state_d = state_q;
        held_d  = held_q;
        if (LOCK_EN && acc) begin
            case (state_q)
                ST_IDLE: begin
                    if (!ch_last) begin
                        state_d = ST_LOCKED;
                        held_d  = ch;
                    end
                end
                ST_LOCKED: begin
                    if (ch_last) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            held_q  <= '0;
        end else begin
            state_q <= state_d;
            held_q  <= held_d;
        end
    end

    // Output stage. SEL_ERR travels with the beat it describes, so it holds
    // together with the rest of the register under backpressure.
    always_ff @(posedge CLK) begin
        if (RST) begin
            dout_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else if (stage_en) begin
            if (acc) begin
                dout_q  <= ch_data;
                last_q  <= ch_last;
                valid_q <= 1'b1;
                err_q   <= sel_bad;
            end else begin
                valid_q <= 1'b0;
                err_q   <= 1'b0;
            end
        end
    end

    assign DOUT      = dout_q;
    assign OUT_LAST  = last_q;
    assign OUT_VALID = valid_q;
    assign SEL_ERR   = err_q;
    assign LOCKED    = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_stream_mux_n.sv
// tb_stream_mux_n
//   Bench for stream_mux_n with NUM_IN=4, WIDTH=32, SEL_W=3 (so SEL can
//   express out-of-range channels) and LOCK_EN=1. Directed sequences follow
//   the usage scenarios; a random phase follows. A behavioural model tracks
//   the output beat, the lock and the held channel as plain integers, and a
//   scoreboard queue checks beat order on the output handshake.

module tb_stream_mux_n;

    localparam int NUM_IN = 4;
    localparam int WIDTH  = 32;
    localparam int SEL_W  = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    rst;
    logic [SEL_W-1:0]        sel;
    logic [WIDTH-1:0]        d_arr [NUM_IN];
    logic [NUM_IN*WIDTH-1:0] d_flat;
    logic [NUM_IN-1:0]       last_v;
    logic [NUM_IN-1:0]       valid_v;
    logic [NUM_IN-1:0]       in_ready;
    logic [WIDTH-1:0]        dout;
    logic                    out_last;
    logic                    out_valid;
    logic                    out_ready;
    logic                    sel_err;
    logic                    locked;

    assign d_flat = {d_arr[3], d_arr[2], d_arr[1], d_arr[0]};

    stream_mux_n #(
        .NUM_IN (NUM_IN),
        .WIDTH  (WIDTH),
        .SEL_W  (SEL_W),
        .LOCK_EN(1'b1)
    ) dut (
        .CLK      (clk),
        .RST      (rst),
        .SEL      (sel),
        .D        (d_flat),
        .IN_LAST  (last_v),
        .IN_VALID (valid_v),
        .IN_READY (in_ready),
        .DOUT     (dout),
        .OUT_LAST (out_last),
        .OUT_VALID(out_valid),
        .OUT_READY(out_ready),
        .SEL_ERR  (sel_err),
        .LOCKED   (locked)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [WIDTH-1:0] exp_q[$];    // beats accepted but not yet drained
    logic [WIDTH-1:0] obs_q[$];    // beats seen leaving the output
    logic [WIDTH-1:0] exp_log[$];  // literal expectation for a directed test

    bit               m_valid  = 1'b0;
    logic [WIDTH-1:0] m_data   = '0;
    bit               m_last   = 1'b0;
    bit               m_err    = 1'b0;
    bit               m_locked = 1'b0;
    int               m_held   = 0;

    // One clock cycle. Inputs are set by the caller just after a falling
    // edge; returns at the next falling edge.
    task automatic tick();
        int              c;
        bit              bad;
        bit              en;
        bit              acc;
        logic [NUM_IN-1:0] exp_rdy;
        logic [WIDTH-1:0]  head;
        #1;
        bad = 1'b0;
        if (m_locked) c = m_held;
        else if (int'(sel) < NUM_IN) c = int'(sel);
        else begin
            c   = 0;
            bad = 1'b1;
        end
        en      = !m_valid || out_ready;
        exp_rdy = (en && !rst) ? NUM_IN'(1 << c) : '0;
        check("in_ready", 64'(in_ready), 64'(exp_rdy));
        acc = en && !rst && valid_v[c];

        // Output handshake: the consumer takes the current beat.
        if (m_valid && out_ready) begin
            obs_q.push_back(dout);
            if (exp_q.size() == 0) begin
                check("sb_empty", 64'(exp_q.size()), 64'd1);
            end else begin
                head = exp_q.pop_front();
                check("sb_data", 64'(dout), 64'(head));
            end
        end

        if (rst) begin
            m_valid  = 1'b0;
            m_data   = '0;
            m_last   = 1'b0;
            m_err    = 1'b0;
            m_locked = 1'b0;
            m_held   = 0;
            exp_q.delete();
        end else if (en) begin
            if (acc) begin
                m_valid = 1'b1;
                m_data  = d_arr[c];
                m_last  = last_v[c];
                m_err   = bad;
                exp_q.push_back(d_arr[c]);
                if (!m_locked && !last_v[c]) begin
                    m_locked = 1'b1;
                    m_held   = c;
                end else if (m_locked && last_v[c]) begin
                    m_locked = 1'b0;
                end
            end else begin
                m_valid = 1'b0;
                m_err   = 1'b0;
            end
        end

        @(posedge clk);
        #1;
        check("out_valid", 64'(out_valid), 64'(m_valid));
        check("dout",      64'(dout),      64'(m_data));
        check("out_last",  64'(out_last),  64'(m_last));
        check("sel_err",   64'(sel_err),   64'(m_err));
        check("locked",    64'(locked),    64'(m_locked));
        @(negedge clk);
    endtask

    task automatic check_log(input string tag);
        check({tag, "_len"}, 64'(obs_q.size()), 64'(exp_log.size()));
        for (int i = 0; i < exp_log.size() && i < obs_q.size(); i++) begin
            check(tag, 64'(obs_q[i]), 64'(exp_log[i]));
        end
        obs_q.delete();
    endtask

    task automatic idle_inputs();
        valid_v = '0;
        last_v  = '0;
        for (int i = 0; i < NUM_IN; i++) d_arr[i] = '0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst       = 1'b1;
        sel       = '0;
        out_ready = 1'b1;
        idle_inputs();
        valid_v   = 4'b1111;
        for (int i = 0; i < NUM_IN; i++) d_arr[i] = 32'hF0 + i;
        @(negedge clk);

        // Reset held for 3 cycles with every channel valid.
        for (int k = 0; k < 3; k++) tick();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_dout", 64'(dout), 64'd0);

        // First beat one cycle after reset falls.
        rst      = 1'b0;
        idle_inputs();
        sel      = 3'd0;
        d_arr[0] = 32'h55;
        last_v   = 4'b0001;
        valid_v  = 4'b0001;
        tick();
        check("first_beat", 64'(dout), 64'h55);
        idle_inputs();
        tick();
        obs_q.delete();

        // Streaming on channel 2, one packet of 8 beats.
        sel = 3'd2;
        for (int k = 0; k < 8; k++) begin
            d_arr[2]  = 32'hA0 + k;
            last_v[2] = (k == 7);
            valid_v   = 4'b0100;
            tick();
        end
        idle_inputs();
        tick();
        exp_log = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hA5, 32'hA6, 32'hA7};
        check_log("stream");

        // Backpressure: 0x1234 parked in the output for 3 cycles.
        sel      = 3'd0;
        d_arr[0] = 32'h1234;
        last_v   = 4'b0001;
        valid_v  = 4'b0001;
        tick();
        d_arr[0]  = 32'h5678;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("bp_dout", 64'(dout), 64'h1234);
            check("bp_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        tick();
        check("bp_next", 64'(dout), 64'h5678);
        idle_inputs();
        tick();
        exp_log = '{32'h1234, 32'h5678};
        check_log("bp");

        // Lock: 3-beat packet on channel 1, SEL moves to 3 after beat 1.
        sel      = 3'd1;
        d_arr[1] = 32'h11;
        valid_v  = 4'b0010;
        tick();
        check("lock_on", 64'(locked), 64'd1);
        sel      = 3'd3;
        d_arr[3] = 32'h3C;
        last_v   = 4'b1000;
        d_arr[1] = 32'h22;
        valid_v  = 4'b1010;
        tick();
        d_arr[1]  = 32'h33;
        last_v[1] = 1'b1;
        tick();
        check("lock_off", 64'(locked), 64'd0);
        valid_v[1] = 1'b0;
        tick();
        idle_inputs();
        tick();
        exp_log = '{32'h11, 32'h22, 32'h33, 32'h3C};
        check_log("lock");

        // Bad select falls back to channel 0.
        sel      = 3'd5;
        d_arr[0] = 32'hDEAD;
        last_v   = 4'b0001;
        valid_v  = 4'b0001;
        tick();
        check("bad_dout", 64'(dout), 64'hDEAD);
        check("bad_err", 64'(sel_err), 64'd1);
        idle_inputs();
        tick();
        check("bad_err_clr", 64'(sel_err), 64'd0);
        obs_q.delete();

        // Reset in the middle of a 4-beat locked packet.
        sel      = 3'd2;
        valid_v  = 4'b0100;
        d_arr[2] = 32'hB1;
        tick();
        d_arr[2] = 32'hB2;
        tick();
        check("mid_locked", 64'(locked), 64'd1);
        d_arr[2] = 32'hB3;
        rst      = 1'b1;
        tick();
        check("mid_rst_locked", 64'(locked), 64'd0);
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        rst      = 1'b0;
        sel      = 3'd1;
        d_arr[1] = 32'h77;
        last_v   = 4'b0010;
        valid_v  = 4'b0110;
        tick();
        check("mid_next", 64'(dout), 64'h77);
        idle_inputs();
        tick();
        obs_q.delete();

        // Random phase.
        for (int k = 0; k < 3000; k++) begin
            rst       = ($urandom_range(0, 199) == 0);
            sel       = SEL_W'($urandom_range(0, 7));
            valid_v   = NUM_IN'($urandom_range(0, 15));
            last_v    = NUM_IN'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < NUM_IN; i++) d_arr[i] = $urandom;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
